button_repeat: RTL and testbench
================================

Name: button_repeat

Overview:
- Consumer end of the debounced button interface: takes a clean, already-debounced level and turns it into discrete events for paddle and menu logic.
- Events: one-cycle press and release pulses, plus a "step" pulse stream with typematic auto-repeat.
- After an initial hold delay, steps repeat at a fixed rate. Delay and rate are measured in ticks of an external strobe, typically one per video frame.
- Sits between the debouncer and the game/paddle controller; one instance per button.

Parameters:
- DELAY_TICKS, 16, ticks from press until the first repeat step; legal range 1..2**CNT_W-1.
- RATE_TICKS, 4, ticks between subsequent repeat steps; legal range 1..2**CNT_W-1.
- CNT_W, 8, width of the internal tick counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- level  in  1  debounced button level, synchronous to clk, 1 = pressed.
- tick  in  1  single-cycle timing strobe; may be asserted on any cycle.
- press  out  1  one-cycle pulse on a rising edge of level.
- release  out  1  one-cycle pulse on a falling edge of level.
- step  out  1  one-cycle pulse on press and on every auto-repeat.
- held  out  1  registered copy of level (1-cycle delayed).

Behaviour:
- Reset:
  - Asynchronous on reset_n low.
  - press, release, step and held are all 0; level_q = 0; state = IDLE; cnt = 0.
  - Release of reset is sampled on clk; no event is generated for a level that is already high at reset release until level_q has captured it. A level high at release yields a press 1 cycle later.
- Edge detection:
  - level_q is a registered copy of level.
  - rise = level & ~level_q; fall = ~level & level_q.
  - All outputs are registered: each pulse appears on the clock edge after the cycle in which its condition is evaluated (latency 1 cycle). held = level_q.
- States: IDLE, DELAY, REPEAT. Evaluation order per cycle: fall, then rise, then tick.
  - Any state, fall: release = 1, state -> IDLE, cnt = 0, no step. fall wins over a simultaneous tick.
  - IDLE, rise: press = 1, step = 1, cnt = DELAY_TICKS, state -> DELAY. A tick in the same cycle is ignored and not counted.
  - DELAY, tick with cnt != 1: cnt = cnt - 1.
  - DELAY, tick with cnt == 1: step = 1, cnt = RATE_TICKS, state -> REPEAT.
  - REPEAT, tick with cnt != 1: cnt = cnt - 1.
  - REPEAT, tick with cnt == 1: step = 1, cnt = RATE_TICKS, stay in REPEAT.
  - No tick: cnt holds.
- Width and arithmetic:
  - cnt is CNT_W bits, unsigned. It never wraps: the decrement only happens when cnt > 1, and reload happens at 1.
  - Parameters outside the legal range are illegal; an initial-block assertion flags them in simulation.
- Pulse widths:
  - press, release and step are each exactly 1 cycle wide; each can be high at most once per event.
  - press and step coincide on the press cycle.
  - release and step are never high together.
- Bounce tolerance: a level toggling every cycle produces alternating press/release pulses with no stuck state. Every rise restarts the DELAY phase from DELAY_TICKS.
- Reset mid-operation: asserting reset_n low immediately clears all state and outputs, including any pulse that was in flight.

Decomposition:
- Shared header button_defs.vh holds:
  - state encodings: IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2;
  - default DELAY_TICKS and RATE_TICKS values, for reuse by paddle and menu logic.
- Natural sub-module: edge_detect (clk, reset_n, in, rise, fall, q), the registered rise/fall detector, reusable elsewhere.
- The FSM and counter stay in button_repeat.

Test Plan (DELAY_TICKS=3, RATE_TICKS=2, tick every 4 cycles):
- Reset: reset_n low with level = 1 -> all outputs 0. After release -> one press + step pulse 1 cycle later, then held = 1.
- Short press: level high for 6 cycles, covering 1 tick -> exactly one press+step pulse and one release pulse; no repeat step.
- Long hold: level high for 9 ticks -> steps on the press cycle, then 1 cycle after ticks 3, 5, 7 and 9. Total 5 step pulses, then release on the falling edge.
- Simultaneous events:
  - fall in the same cycle as the tick that would fire a repeat -> release only, no step, state IDLE.
  - rise in the same cycle as a tick -> cnt loads 3, and that tick is not counted.
- Bounce: level toggling 1/0 for 8 cycles -> 4 press and 4 release pulses, each 1 cycle wide, never overlapping; no repeat step.
- Async reset mid-REPEAT: reset_n low between ticks -> outputs clear without waiting for a clk edge. After release with level still high -> a new press+step, and the DELAY phase restarts (first repeat after 3 ticks).

Source files
------------

// File: rtl/button_repeat_pkg.sv
// Shared definitions for the button repeat block: state encodings and the
// default hold delay / repeat rate, reusable by paddle and menu logic.
package button_repeat_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam int DEF_DELAY_TICKS = 16;
  localparam int DEF_RATE_TICKS  = 4;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/button_repeat_if.sv
// Button event bus between the debouncer side (master) and the event
// generator (slave): a clean level and timing strobe in, event pulses out.
interface button_repeat_if;
  logic level;
  logic tick;
  logic press;
  logic release_pulse;
  logic step;
  logic held;

  modport master (
    output level, tick,
    input  press, release_pulse, step, held
  );

  modport slave (
    input  level, tick,
    output press, release_pulse, step, held
  );
endinterface

// File: rtl/button_repeat_edge_detect.sv
// Registered copy of a synchronous level with combinational rise/fall
// flags derived from the current input against the registered copy.
module button_repeat_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic in,
  output logic rise,
  output logic fall,
  output logic q
);

  // previous-cycle copy of the input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= 1'b0;
    else          q <= in;
  end

  assign rise = in & ~q;
  assign fall = ~in & q;

endmodule

// File: rtl/button_repeat.sv
// Turns a debounced button level into press/release pulses plus a step
// pulse stream with typematic auto-repeat timed in external ticks.
//
// state  | meaning
// IDLE   | button released, waiting for a rising edge
// DELAY  | held, counting down the initial hold delay
// REPEAT | held, emitting a step every RATE_TICKS ticks
module button_repeat
  import button_repeat_pkg::*;
#(
  parameter int DELAY_TICKS = DEF_DELAY_TICKS,
  parameter int RATE_TICKS  = DEF_RATE_TICKS,
  parameter int CNT_W       = DEF_CNT_W
) (
  input logic           clk,
  input logic           reset_n,
  button_repeat_if.slave bus
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  if (DELAY_TICKS < 1 || DELAY_TICKS > CNT_MAX) begin : g_bad_delay
    $error("button_repeat: DELAY_TICKS out of range 1..2**CNT_W-1");
  end
  if (RATE_TICKS < 1 || RATE_TICKS > CNT_MAX) begin : g_bad_rate
    $error("button_repeat: RATE_TICKS out of range 1..2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'(DELAY_TICKS);
  localparam logic [CNT_W-1:0] RATE_LD  = CNT_W'(RATE_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             rise;
  logic             fall;
  logic             level_q;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  button_repeat_edge_detect u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (bus.level),
    .rise    (rise),
    .fall    (fall),
    .q       (level_q)
  );

  assign bus.held = level_q;

  // FSM and tick down-counter; fall beats rise beats tick, pulses registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      cnt               <= '0;
      bus.press         <= 1'b0;
      bus.release_pulse <= 1'b0;
      bus.step          <= 1'b0;
    end else begin
      bus.press         <= 1'b0;
      bus.release_pulse <= 1'b0;
      bus.step          <= 1'b0;
      if (fall) begin
        bus.release_pulse <= 1'b1;
        state             <= IDLE;
        cnt               <= '0;
      end else begin
        case (state)
          IDLE: begin
            // a tick coinciding with the press is deliberately not counted
            if (rise) begin
              bus.press <= 1'b1;
              bus.step  <= 1'b1;
              cnt       <= DELAY_LD;
              state     <= DELAY;
            end
          end
          DELAY, REPEAT: begin
            if (bus.tick) begin
              if (cnt == CNT_ONE) begin
                bus.step <= 1'b1;
                cnt      <= RATE_LD;
                state    <= REPEAT;
              end else begin
                cnt <= cnt - CNT_ONE;
              end
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_repeat.sv
// Bench for button_repeat with DELAY_TICKS=3, RATE_TICKS=2.
module tb_button_repeat;
  localparam int D = 3;
  localparam int R = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  button_repeat_if bif ();

  button_repeat #(.DELAY_TICKS(D), .RATE_TICKS(R), .CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  int n_cmp = 0;
  int n_err = 0;

  // reference model: tick count since the last press decides the steps
  bit m_q      = 1'b0;
  bit m_active = 1'b0;
  int m_ticks  = 0;
  bit e_press, e_rel, e_step, e_held;

  int cyc = 0;
  int cnt_step = 0, cnt_press = 0, cnt_rel = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0d, want %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = 1'b0; m_active = 1'b0; m_ticks = 0;
  endtask

  // one clock: drive inputs, predict, clock, compare all outputs
  task automatic do_cycle(input bit lvl, input bit tk);
    bit rise, fall;
    bif.level = lvl;
    bif.tick  = tk;
    rise = lvl && !m_q;
    fall = !lvl && m_q;
    e_press = rise;
    e_rel   = fall;
    e_step  = rise;
    if (fall) begin
      m_active = 1'b0;
    end else if (rise) begin
      m_active = 1'b1;
      m_ticks  = 0;
    end else if (m_active && tk) begin
      m_ticks++;
      if (m_ticks == D || (m_ticks > D && (m_ticks - D) % R == 0)) e_step = 1'b1;
    end
    m_q = lvl;
    e_held = lvl;
    @(posedge clk);
    #1;
    cyc++;
    check("press", bif.press, e_press);
    check("release", bif.release_pulse, e_rel);
    check("step", bif.step, e_step);
    check("held", bif.held, e_held);
    if (bif.step) cnt_step++;
    if (bif.press) cnt_press++;
    if (bif.release_pulse) cnt_rel++;
  endtask

  // directed cycles with a tick every 4th cycle
  task automatic run(input bit lvl, input int n);
    for (int i = 0; i < n; i++) do_cycle(lvl, (cyc % 4) == 3);
  endtask

  task automatic align(input bit lvl, input int phase);
    while ((cyc % 4) != phase) do_cycle(lvl, (cyc % 4) == 3);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_press"}, bif.press, 0);
    check({tag, "_release"}, bif.release_pulse, 0);
    check({tag, "_step"}, bif.step, 0);
    check({tag, "_held"}, bif.held, 0);
  endtask

  initial begin
    bit lvl;
    bit tk;
    bif.level = 1'b1;
    bif.tick  = 1'b0;

    // reset with level already high
    repeat (3) @(posedge clk);
    #1;
    check_cleared("rst");
    reset_n = 1'b1;
    model_reset();
    do_cycle(1'b1, 1'b0);
    check("rst_press_first", bif.press, 1);
    run(1'b1, 2);
    run(1'b0, 2);

    // short press covering one tick
    align(1'b0, 0);
    cnt_step = 0; cnt_press = 0; cnt_rel = 0;
    run(1'b1, 6);
    run(1'b0, 2);
    check("short_steps", cnt_step, 1);
    check("short_press", cnt_press, 1);
    check("short_rel", cnt_rel, 1);

    // long hold across 9 ticks
    align(1'b0, 0);
    cnt_step = 0; cnt_rel = 0;
    run(1'b1, 36);
    check("long_steps", cnt_step, 5);
    run(1'b0, 1);
    check("long_rel", cnt_rel, 1);

    // fall on the tick that would fire the first repeat
    align(1'b0, 0);
    run(1'b1, 11);
    do_cycle(1'b0, 1'b1);
    check("fall_tick_step", bif.step, 0);
    check("fall_tick_rel", bif.release_pulse, 1);
    run(1'b0, 4);

    // rise on a tick cycle: that tick is not counted
    align(1'b0, 3);
    cnt_step = 0;
    run(1'b1, 13);
    check("rise_tick_steps", cnt_step, 2);
    run(1'b0, 2);

    // bounce: toggle every cycle
    cnt_step = 0; cnt_press = 0; cnt_rel = 0;
    for (int i = 0; i < 8; i++) do_cycle((i % 2) == 0, (cyc % 4) == 3);
    check("bounce_press", cnt_press, 4);
    check("bounce_rel", cnt_rel, 4);
    check("bounce_steps", cnt_step, 4);
    run(1'b0, 2);

    // async reset in the middle of REPEAT, between clock edges
    align(1'b0, 0);
    run(1'b1, 20);
    #2;
    reset_n = 1'b0;
    #1;
    check_cleared("async");
    @(posedge clk);
    #1;
    check_cleared("async_hold");
    reset_n = 1'b1;
    model_reset();
    cnt_step = 0;
    run(1'b1, 16);
    run(1'b0, 2);

    // randomized level/tick traffic
    lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) lvl = ~lvl;
      if ($urandom_range(0, 63) == 0) begin
        for (int j = 0; j < 6; j++) begin
          lvl = ~lvl;
          do_cycle(lvl, $urandom_range(0, 2) == 0);
        end
      end
      tk = ($urandom_range(0, 2) == 0);
      do_cycle(lvl, tk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
